// File: rtl/fp_reduce_tree_stream.sv
// Streaming max/min reduction of IEEE-754 lanes. A registered pairwise compare tree
// feeds a per-packet accumulator, and the accumulator result lands in a stallable output register.
module fp_reduce_tree_stream #(
  parameter int OP_NUM     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int EXPO_WIDTH = 8,
  parameter int MANT_WIDTH = 23,
  parameter int BEAT_W     = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [OP_NUM*DATA_WIDTH-1:0]     in_data,
  input  logic [OP_NUM-1:0]                in_mask,
  input  logic                             in_valid,
  input  logic                             in_last,
  input  logic                             in_mode_min,
  output logic                             in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [BEAT_W+$clog2(OP_NUM)-1:0] out_index,
  output logic                             out_empty,
  output logic                             out_nan,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int LVLS  = $clog2(OP_NUM);
  localparam int IDX_W = BEAT_W + LVLS;

  localparam logic [DATA_WIDTH-1:0] QNAN =
    DATA_WIDTH'({1'b0, {EXPO_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}});
  localparam logic [DATA_WIDTH-1:0] POS_INF =
    DATA_WIDTH'({1'b0, {EXPO_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}});
  localparam logic [DATA_WIDTH-1:0] NEG_INF =
    DATA_WIDTH'({1'b1, {EXPO_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}});

  typedef struct packed {
    logic                  vld;
    logic                  nan;
    logic [DATA_WIDTH-1:0] data;
    logic [IDX_W-1:0]      idx;
  } cand_t;

  function automatic logic is_nan(input logic [DATA_WIDTH-1:0] x);
    return (&x[MANT_WIDTH +: EXPO_WIDTH]) && (|x[MANT_WIDTH-1:0]);
  endfunction

  // Map sign-magnitude onto an unsigned order; both zeros share a single key.
  function automatic logic [DATA_WIDTH-1:0] ord_key(input logic [DATA_WIDTH-1:0] x);
    if (x[DATA_WIDTH-2:0] == '0) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    if (x[DATA_WIDTH-1])         return ~x;
    return {1'b1, x[DATA_WIDTH-2:0]};
  endfunction

  // 'a' always holds the lower index, so ties and NaN-vs-NaN go to 'a'.
  function automatic logic first_wins(input cand_t a, input cand_t b, input logic mode_min);
    logic [DATA_WIDTH-1:0] ka;
    logic [DATA_WIDTH-1:0] kb;
    ka = ord_key(a.data);
    kb = ord_key(b.data);
    if (!b.vld)   return 1'b1;
    if (!a.vld)   return 1'b0;
    if (a.nan)    return 1'b1;
    if (b.nan)    return 1'b0;
    if (ka == kb) return 1'b1;
    return mode_min ? (ka < kb) : (ka > kb);
  endfunction

  logic                  stall;
  logic                  accept;
  logic                  beat_mode;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                  first_q, first_d;
  logic                  pkt_mode_q, pkt_mode_d;
  logic [LVLS:1]         vld_q, vld_d, last_q, last_d, mode_q, mode_d;
  logic [LVLS:0]         lvl_vld, lvl_last, lvl_mode;
  cand_t                 lane_c [OP_NUM];
  cand_t                 tree_c [0:LVLS][OP_NUM];
  cand_t                 node_q [1:LVLS][OP_NUM];
  cand_t                 node_d [1:LVLS][OP_NUM];
  cand_t                 acc_q, acc_d;
  cand_t                 tree_top, merged;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]      out_index_q, out_index_d;
  logic                  out_empty_q, out_empty_d;
  logic                  out_nan_q, out_nan_d;

  always_comb begin
    // NOTE: every _d starts from its _q, so no path through this block can infer a latch.
    beat_cnt_d  = beat_cnt_q;
    first_d     = first_q;
    pkt_mode_d  = pkt_mode_q;
    vld_d       = vld_q;
    last_d      = last_q;
    mode_d      = mode_q;
    node_d      = node_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_empty_d = out_empty_q;
    out_nan_d   = out_nan_q;

    stall     = out_valid_q && !out_ready;
    accept    = in_valid && !stall;
    beat_mode = first_q ? in_mode_min : pkt_mode_q;

    for (int i = 0; i < OP_NUM; i++) begin
      lane_c[i].vld  = in_mask[i];
      lane_c[i].data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      lane_c[i].nan  = in_mask[i] && is_nan(in_data[i*DATA_WIDTH +: DATA_WIDTH]);
      lane_c[i].idx  = {beat_cnt_q, LVLS'(i)};
    end

    tree_c[0] = lane_c;
    for (int k = 1; k <= LVLS; k++) tree_c[k] = node_q[k];
    lvl_vld  = {vld_q, accept};
    lvl_last = {last_q, in_last};
    lvl_mode = {mode_q, beat_mode};

    tree_top = node_q[LVLS][0];
    merged   = first_wins(acc_q, tree_top, mode_q[LVLS]) ? acc_q : tree_top;

    if (!stall) begin
      if (accept) begin
        beat_cnt_d = in_last ? '0 : beat_cnt_q + BEAT_W'(1);
        first_d    = in_last;
        if (first_q) pkt_mode_d = in_mode_min;
      end

      vld_d  = lvl_vld[LVLS-1:0];
      last_d = lvl_last[LVLS-1:0];
      mode_d = lvl_mode[LVLS-1:0];
      for (int s = 1; s <= LVLS; s++) begin
        for (int i = 0; i < (OP_NUM >> s); i++) begin
          node_d[s][i] = first_wins(tree_c[s-1][2*i], tree_c[s-1][2*i+1], lvl_mode[s-1])
                       ? tree_c[s-1][2*i] : tree_c[s-1][2*i+1];
        end
      end

      // Clearing on the last beat lets the next packet's first beat merge into an empty accumulator.
      if (vld_q[LVLS]) acc_d = last_q[LVLS] ? '0 : merged;

      out_valid_d = 1'b0;
      if (vld_q[LVLS] && last_q[LVLS]) begin
        out_valid_d = 1'b1;
        out_empty_d = !merged.vld;
        out_nan_d   = merged.nan;
        out_index_d = merged.vld ? merged.idx : '1;
        if (!merged.vld)     out_data_d = mode_q[LVLS] ? POS_INF : NEG_INF;
        else if (merged.nan) out_data_d = QNAN;
        else                 out_data_d = merged.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: tree data is cleared along with the valid flags; these arrays are plain flops, not RAM.
      beat_cnt_q  <= '0;
      first_q     <= 1'b1;
      pkt_mode_q  <= 1'b0;
      vld_q       <= '0;
      last_q      <= '0;
      mode_q      <= '0;
      for (int s = 1; s <= LVLS; s++) begin
        for (int i = 0; i < OP_NUM; i++) node_q[s][i] <= '0;
      end
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_empty_q <= 1'b0;
      out_nan_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value of its peers.
      beat_cnt_q  <= beat_cnt_d;
      first_q     <= first_d;
      pkt_mode_q  <= pkt_mode_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
      mode_q      <= mode_d;
      node_q      <= node_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_empty_q <= out_empty_d;
      out_nan_q   <= out_nan_d;
    end
  end

  assign in_ready  = !stall;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_empty = out_empty_q;
  assign out_nan   = out_nan_q;

endmodule

// File: tb/tb_fp_reduce_tree_stream.sv
// Directed bench for fp_reduce_tree_stream with OP_NUM=4 and hand-computed expected results.
module tb_fp_reduce_tree_stream;

  localparam int OP_NUM = 4;
  localparam int DW     = 32;
  localparam int BEAT_W = 8;
  localparam int IDX_W  = 10;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [OP_NUM*DW-1:0] in_data;
  logic [OP_NUM-1:0]    in_mask;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_mode_min;
  logic                 in_ready;
  logic [DW-1:0]        out_data;
  logic [IDX_W-1:0]     out_index;
  logic                 out_empty;
  logic                 out_nan;
  logic                 out_valid;
  logic                 out_ready;

  fp_reduce_tree_stream #(
    .OP_NUM(OP_NUM), .DATA_WIDTH(DW), .EXPO_WIDTH(8), .MANT_WIDTH(23), .BEAT_W(BEAT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_mask(in_mask), .in_valid(in_valid),
    .in_last(in_last), .in_mode_min(in_mode_min), .in_ready(in_ready), .out_data(out_data),
    .out_index(out_index), .out_empty(out_empty), .out_nan(out_nan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]    data;
    logic [IDX_W-1:0] idx;
    logic             empty;
    logic             nan;
  } res_t;

  res_t res_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pk(input logic [31:0] l0, input logic [31:0] l1,
                                      input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Records each consumed result between edges, after inputs have settled.
  initial begin
    forever begin
      res_t r;
      @(negedge clk);
      #2;
      if (out_valid && out_ready) begin
        r.data  = out_data;
        r.idx   = out_index;
        r.empty = out_empty;
        r.nan   = out_nan;
        res_q.push_back(r);
      end
    end
  end

  // Called just after a negedge; returns at the negedge following the accepting posedge.
  task automatic send_beat(input logic [127:0] d, input logic [3:0] m,
                           input logic last, input logic mode);
    logic ok;
    ok          = 1'b0;
    in_data     = d;
    in_mask     = m;
    in_last     = last;
    in_mode_min = mode;
    in_valid    = 1'b1;
    for (int n = 0; n < 64; n++) begin
      #1;
      ok = in_ready;
      @(negedge clk);
      if (ok) break;
    end
    in_valid = 1'b0;
    check("beat_accepted", ok, 1);
  endtask

  task automatic expect_res(input string tag, input logic [31:0] d, input logic [IDX_W-1:0] ix,
                            input logic em, input logic nn);
    res_t r;
    int   n;
    n = 0;
    while (res_q.size() == 0 && n < 64) begin
      @(negedge clk);
      #3;
      n++;
    end
    check({tag, "_arrived"}, (res_q.size() != 0), 1);
    if (res_q.size() != 0) begin
      r = res_q.pop_front();
      check({tag, "_data"},  r.data,  d);
      check({tag, "_index"}, r.idx,   ix);
      check({tag, "_empty"}, r.empty, em);
      check({tag, "_nan"},   r.nan,   nn);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_mask     = '0;
    in_last     = 1'b0;
    in_mode_min = 1'b0;
    out_ready   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_index", out_index, 0);
    check("rst_out_empty", out_empty, 0);
    check("rst_out_nan",   out_nan,   0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);

    // Max, single beat, tie between lanes 1 and 3; result visible 3 cycles after acceptance.
    send_beat(pk(32'h3F800000, 32'h40600000, 32'hC0000000, 32'h40600000), 4'hF, 1'b1, 1'b0);
    check("lat_cycle1", out_valid, 0);
    @(negedge clk);
    check("lat_cycle2", out_valid, 0);
    @(negedge clk);
    check("lat_cycle3", out_valid, 1);
    check("s1_data",  out_data,  32'h40600000);
    check("s1_index", out_index, 1);
    check("s1_nan",   out_nan,   0);
    check("s1_empty", out_empty, 0);
    @(negedge clk);
    res_q.delete();

    // Min, three beats, -7.0 at beat 2 lane 3.
    send_beat(pk(32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3F000000), 4'hF, 1'b0, 1'b1);
    send_beat(pk(32'hC0400000, 32'h40800000, 32'h00000000, 32'h80000000), 4'hF, 1'b0, 1'b1);
    send_beat(pk(32'h40A00000, 32'hC0C00000, 32'h3F800000, 32'hC0E00000), 4'hF, 1'b1, 1'b1);
    expect_res("min3", 32'hC0E00000, 11, 1'b0, 1'b0);

    // First NaN at beat 1 lane 0, second NaN at lane 1, +inf earlier.
    send_beat(pk(32'h3F800000, 32'h7F800000, 32'h40000000, 32'h40400000), 4'hF, 1'b0, 1'b0);
    send_beat(pk(32'h7F800001, 32'h7FC00000, 32'h3F800000, 32'h00000000), 4'hF, 1'b1, 1'b0);
    expect_res("nan", 32'h7FC00000, 4, 1'b0, 1'b1);

    // Fully masked packets in both modes.
    send_beat(pk(32'h3F800000, 32'h40000000, 32'h7F800001, 32'h40400000), 4'h0, 1'b0, 1'b0);
    send_beat(pk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000), 4'h0, 1'b1, 1'b0);
    expect_res("empty_max", 32'hFF800000, 10'h3FF, 1'b1, 1'b0);
    send_beat(pk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000), 4'h0, 1'b1, 1'b1);
    expect_res("empty_min", 32'h7F800000, 10'h3FF, 1'b1, 1'b0);

    // -0 equals +0 in max mode: lane 0 (-0) wins on the tie.
    send_beat(pk(32'h80000000, 32'h00000000, 32'hBF800000, 32'hC0000000), 4'hF, 1'b1, 1'b0);
    expect_res("zero_tie", 32'h80000000, 0, 1'b0, 1'b0);

    // Denormals compared exactly; large masked lane must lose.
    send_beat(pk(32'h00000001, 32'h00000003, 32'h80000005, 32'h7F000000), 4'h7, 1'b1, 1'b0);
    expect_res("denorm_mask", 32'h00000003, 1, 1'b0, 1'b0);

    // Min with -inf present.
    send_beat(pk(32'hFF800000, 32'hC0000000, 32'h7F800000, 32'h3F800000), 4'hF, 1'b1, 1'b1);
    expect_res("neg_inf_min", 32'hFF800000, 0, 1'b0, 1'b0);

    // Cross-beat tie goes to the earlier beat; mode flip on beat 1 is ignored.
    send_beat(pk(32'h3F800000, 32'h00000000, 32'h00000000, 32'h40800000), 4'hF, 1'b0, 1'b0);
    send_beat(pk(32'h40800000, 32'h40800000, 32'h40000000, 32'h00000000), 4'hF, 1'b1, 1'b1);
    expect_res("tie_beats", 32'h40800000, 3, 1'b0, 1'b0);

    // Stall: three packets streamed while out_ready is low for five result cycles.
    @(negedge clk);
    res_q.delete();
    out_ready = 1'b0;
    fork
      begin
        send_beat(pk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000), 4'hF, 1'b1, 1'b0);
        send_beat(pk(32'h40000000, 32'h3F800000, 32'h40400000, 32'h40800000), 4'hF, 1'b0, 1'b1);
        send_beat(pk(32'h3F000000, 32'h41000000, 32'hBF800000, 32'h40C00000), 4'hF, 1'b1, 1'b0);
        send_beat(pk(32'h40A00000, 32'hC0400000, 32'h41100000, 32'h41200000), 4'h3, 1'b1, 1'b0);
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 32) begin
          @(negedge clk);
          n++;
        end
        check("stall_out_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
          check("stall_in_ready", in_ready, 0);
          check("stall_data",     out_data, 32'h40800000);
          check("stall_index",    out_index, 3);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    expect_res("stall_a", 32'h40800000, 3, 1'b0, 1'b0);
    expect_res("stall_b", 32'hBF800000, 6, 1'b0, 1'b0);
    expect_res("stall_c", 32'h40A00000, 0, 1'b0, 1'b0);

    // Reset after two beats of a three-beat packet discards it.
    @(negedge clk);
    send_beat(pk(32'h42C80000, 32'h3F800000, 32'h40000000, 32'h40400000), 4'hF, 1'b0, 1'b0);
    send_beat(pk(32'h42C80000, 32'h3F800000, 32'h40000000, 32'h40400000), 4'hF, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("ready_after_midrst", in_ready, 1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("midrst_no_valid", seen, 0);
    check("midrst_no_result", res_q.size(), 0);
    send_beat(pk(32'hC0A00000, 32'hBF800000, 32'hC0000000, 32'h42C80000), 4'h7, 1'b1, 1'b0);
    expect_res("after_rst", 32'hBF800000, 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
